// File: rtl/count_mon_pkg.sv
// Shared widths, transition classes and 7-segment constants for count_monitor.
package count_mon_pkg;

  localparam int unsigned CNT_W_DEF  = 4;
  localparam int unsigned WRAP_W_DEF = 8;
  localparam int unsigned DROP_W_DEF = 4;

  typedef enum logic [1:0] {HOLD, STEP, WRAP, ILLEGAL} trans_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} for hex digits 0..F.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_decode.sv
// Registered hex-to-7-segment decoder; only instantiated when SEG7_EN is defined.
module seg7_decode
  import count_mon_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] val_i,
  output logic [6:0] seg_n_o
);

  logic [6:0] seg_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_q <= SEG_BLANK;
    end else begin
      seg_q <= SEG_LUT[val_i];
    end
  end

  assign seg_n_o = seg_q;

endmodule

// File: rtl/count_monitor.sv
// Watches a down-counter bus, flags illegal steps and reports underflow wraps as events.
// Optional SEG7_EN adds a registered 7-segment view of count_q on seg_n.
module count_monitor
  import count_mon_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned WRAP_W = WRAP_W_DEF,
  parameter int unsigned DROP_W = DROP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  count_in,
  input  logic              evt_ready,
  input  logic              clr_err,
  output logic [CNT_W-1:0]  count_q,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              evt_valid,
  output logic [WRAP_W-1:0] evt_data,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              seq_err
`ifdef SEG7_EN
  ,
  output logic [6:0]        seg_n
`endif
);

  localparam logic [CNT_W-1:0]  WrapVal = '1;
  localparam logic [DROP_W-1:0] DropMax = '1;

  logic [CNT_W-1:0]  cnt_q;
  logic              prev_valid_q;
  logic              wrap_det_q, wrap_det_d;
  logic              wrap_pulse_q;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              evt_valid_q, evt_valid_d;
  logic [WRAP_W-1:0] evt_data_q, evt_data_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              seq_err_q, seq_err_d;
  trans_e            trans;
  logic              accept;
  logic              drop;

  always_comb begin
    trans = ILLEGAL;
    if (count_in == cnt_q) begin
      trans = HOLD;
    end else if (cnt_q != '0 && count_in == cnt_q - CNT_W'(1)) begin
      trans = STEP;
    end else if (cnt_q == '0 && count_in == WrapVal) begin
      trans = WRAP;
    end
  end

  // Wrap effects are applied one edge after detection, so they act on wrap_det_q.
  always_comb begin
    wrap_det_d  = prev_valid_q && (trans == WRAP);
    seq_err_d   = seq_err_q;
    wrap_cnt_d  = wrap_cnt_q + WRAP_W'(wrap_det_q);
    evt_valid_d = evt_valid_q;
    evt_data_d  = evt_data_q;
    drop_d      = drop_q;
    accept      = evt_valid_q && evt_ready;
    drop        = 1'b0;

    if (clr_err) seq_err_d = 1'b0;
    if (prev_valid_q && trans == ILLEGAL) seq_err_d = 1'b1;

    if (wrap_det_q) begin
      if (!evt_valid_q || accept) begin
        evt_valid_d = 1'b1;
        evt_data_d  = wrap_cnt_q + WRAP_W'(1);
      end else begin
        drop = 1'b1;
      end
    end else if (accept) begin
      evt_valid_d = 1'b0;
    end

    if (drop) begin
      if (drop_q != DropMax) drop_d = drop_q + DROP_W'(1);
    end else if (clr_err) begin
      drop_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '1;
      prev_valid_q <= 1'b0;
      wrap_det_q   <= 1'b0;
      wrap_pulse_q <= 1'b0;
      wrap_cnt_q   <= '0;
      evt_valid_q  <= 1'b0;
      evt_data_q   <= '0;
      drop_q       <= '0;
      seq_err_q    <= 1'b0;
    end else begin
      cnt_q        <= count_in;
      prev_valid_q <= 1'b1;
      wrap_det_q   <= wrap_det_d;
      wrap_pulse_q <= wrap_det_q;
      wrap_cnt_q   <= wrap_cnt_d;
      evt_valid_q  <= evt_valid_d;
      evt_data_q   <= evt_data_d;
      drop_q       <= drop_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign count_q    = cnt_q;
  assign wrap_pulse = wrap_pulse_q;
  assign wrap_cnt   = wrap_cnt_q;
  assign evt_valid  = evt_valid_q;
  assign evt_data   = evt_data_q;
  assign drop_cnt   = drop_q;
  assign seq_err    = seq_err_q;

`ifdef SEG7_EN
  seg7_decode u_seg7_decode (
    .clk     (clk),
    .rst     (rst),
    .val_i   (cnt_q[3:0]),
    .seg_n_o (seg_n)
  );
`endif

endmodule

// File: tb/tb_count_monitor.sv
// Self-checking bench for count_monitor: vector table, directed corner cases, random vs model.
module tb_count_monitor;

  logic       clk;
  logic       rst;
  logic [3:0] count_in;
  logic       evt_ready;
  logic       clr_err;
  logic [3:0] count_q;
  logic       wrap_pulse;
  logic [7:0] wrap_cnt;
  logic       evt_valid;
  logic [7:0] evt_data;
  logic [3:0] drop_cnt;
  logic       seq_err;
`ifdef SEG7_EN
  logic [6:0] seg_n;
`endif

  int n_pass;
  int n_total;

  // Reference model state, plain integers.
  int m_prev;   // -1: no sample since reset
  int m_det;
  int m_cq, m_wp, m_wc, m_ev, m_ed, m_drop, m_err, m_seg;

  count_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .count_in   (count_in),
    .evt_ready  (evt_ready),
    .clr_err    (clr_err),
    .count_q    (count_q),
    .wrap_pulse (wrap_pulse),
    .wrap_cnt   (wrap_cnt),
    .evt_valid  (evt_valid),
    .evt_data   (evt_data),
    .drop_cnt   (drop_cnt),
    .seq_err    (seq_err)
`ifdef SEG7_EN
    ,
    .seg_n      (seg_n)
`endif
  );

  always #5 clk = ~clk;

  function automatic int seg_of(int v);
    case (v)
      0: return 'h40;  1: return 'h79;  2: return 'h24;  3: return 'h30;
      4: return 'h19;  5: return 'h12;  6: return 'h02;  7: return 'h78;
      8: return 'h00;  9: return 'h10; 10: return 'h08; 11: return 'h03;
      12: return 'h46; 13: return 'h21; 14: return 'h06; default: return 'h0E;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_prev = -1; m_det = 0; m_cq = 15; m_wp = 0; m_wc = 0;
    m_ev = 0; m_ed = 0; m_drop = 0; m_err = 0; m_seg = 'h7F;
  endtask

  task automatic model_edge(input int cin, input int rdy, input int clr);
    int wrap_now;
    int new_det;
    int illegal;
    int dropped;
    wrap_now = m_det;
    new_det  = 0;
    illegal  = 0;
    dropped  = 0;
    if (m_prev >= 0) begin
      if (cin == m_prev) ;
      else if (m_prev > 0 && cin == m_prev - 1) ;
      else if (m_prev == 0 && cin == 15) new_det = 1;
      else illegal = 1;
    end
    if (illegal != 0) m_err = 1;
    else if (clr != 0) m_err = 0;
    m_wp = wrap_now;
    if (wrap_now != 0) begin
      m_wc = (m_wc + 1) % 256;
      if (m_ev == 0 || rdy != 0) begin
        m_ev = 1;
        m_ed = m_wc;
      end else begin
        dropped = 1;
      end
    end else if (m_ev != 0 && rdy != 0) begin
      m_ev = 0;
    end
    if (dropped != 0) m_drop = (m_drop < 15) ? m_drop + 1 : 15;
    else if (clr != 0) m_drop = 0;
    m_seg  = seg_of(m_cq);
    m_cq   = cin;
    m_prev = cin;
    m_det  = new_det;
  endtask

  task automatic compare_model();
    chk("count_q", int'(count_q), m_cq);
    chk("wrap_pulse", int'(wrap_pulse), m_wp);
    chk("wrap_cnt", int'(wrap_cnt), m_wc);
    chk("evt_valid", int'(evt_valid), m_ev);
    if (m_ev != 0) chk("evt_data", int'(evt_data), m_ed);
    chk("drop_cnt", int'(drop_cnt), m_drop);
    chk("seq_err", int'(seq_err), m_err);
`ifdef SEG7_EN
    chk("seg_n", int'(seg_n), m_seg);
`endif
  endtask

  task automatic step(input int cin, input int rdy, input int clr);
    count_in  = 4'(cin);
    evt_ready = rdy[0];
    clr_err   = clr[0];
    @(posedge clk);
    model_edge(cin, rdy, clr);
    #1;
    compare_model();
  endtask

  // Asserts reset away from the clock edge and checks outputs clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_count_q", int'(count_q), 15);
    chk("rst_wrap_pulse", int'(wrap_pulse), 0);
    chk("rst_wrap_cnt", int'(wrap_cnt), 0);
    chk("rst_evt_valid", int'(evt_valid), 0);
    chk("rst_evt_data", int'(evt_data), 0);
    chk("rst_drop_cnt", int'(drop_cnt), 0);
    chk("rst_seq_err", int'(seq_err), 0);
`ifdef SEG7_EN
    chk("rst_seg_n", int'(seg_n), 'h7F);
`endif
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Counts 14..0 then 15 starting from count 15; the wrap lands on the following edge.
  task automatic wrap_cycle(input int rdy);
    for (int v = 14; v >= 0; v--) step(v, rdy, 0);
    step(15, rdy, 0);
  endtask

  typedef struct {
    int cin;
    int rdy;
    int cq;
    int wp;
    int wc;
    int ev;
    int ed;
    int err;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int cur;
    int r;
    clk       = 1'b0;
    rst       = 1'b0;
    count_in  = 4'hF;
    evt_ready = 1'b0;
    clr_err   = 1'b0;
    n_pass    = 0;
    n_total   = 0;
    model_reset();

    // Full countdown with ready high: single wrap, single event, accepted next cycle.
    tbl[0] = '{cin: 15, rdy: 1, cq: 15, wp: 0, wc: 0, ev: 0, ed: 0, err: 0};
    for (int i = 1; i <= 15; i++)
      tbl[i] = '{cin: 15 - i, rdy: 1, cq: 15 - i, wp: 0, wc: 0, ev: 0, ed: 0, err: 0};
    tbl[16] = '{cin: 15, rdy: 1, cq: 15, wp: 0, wc: 0, ev: 0, ed: 0, err: 0};
    tbl[17] = '{cin: 15, rdy: 1, cq: 15, wp: 1, wc: 1, ev: 1, ed: 1, err: 0};
    tbl[18] = '{cin: 15, rdy: 1, cq: 15, wp: 0, wc: 1, ev: 0, ed: 0, err: 0};

    do_reset();
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].cin, tbl[i].rdy, 0);
      chk($sformatf("tbl%0d_count_q", i), int'(count_q), tbl[i].cq);
      chk($sformatf("tbl%0d_wrap_pulse", i), int'(wrap_pulse), tbl[i].wp);
      chk($sformatf("tbl%0d_wrap_cnt", i), int'(wrap_cnt), tbl[i].wc);
      chk($sformatf("tbl%0d_evt_valid", i), int'(evt_valid), tbl[i].ev);
      if (tbl[i].ev != 0) chk($sformatf("tbl%0d_evt_data", i), int'(evt_data), tbl[i].ed);
      chk($sformatf("tbl%0d_seq_err", i), int'(seq_err), tbl[i].err);
    end

    // Three wraps with no consumer: first event held, two dropped.
    do_reset();
    step(15, 0, 0);
    for (int k = 0; k < 3; k++) wrap_cycle(0);
    step(15, 0, 0);
    chk("hold_evt_valid", int'(evt_valid), 1);
    chk("hold_evt_data", int'(evt_data), 1);
    chk("hold_drop_cnt", int'(drop_cnt), 2);
    chk("hold_wrap_cnt", int'(wrap_cnt), 3);
    step(15, 1, 0);
    chk("accept_evt_valid", int'(evt_valid), 0);

    // Illegal jump, sticky flag, clear, and set-beats-clear.
    for (int v = 14; v >= 9; v--) step(v, 0, 0);
    step(5, 0, 0);
    chk("jump_seq_err", int'(seq_err), 1);
    step(5, 0, 0);
    chk("sticky_seq_err", int'(seq_err), 1);
    step(5, 0, 1);
    chk("clr_seq_err", int'(seq_err), 0);
    chk("clr_drop_cnt", int'(drop_cnt), 0);
    step(7, 0, 0);
    step(7, 0, 1);
    chk("clr2_seq_err", int'(seq_err), 0);
    step(2, 0, 1);
    chk("set_wins_seq_err", int'(seq_err), 1);

    // Twenty drops saturate the 4-bit counter.
    do_reset();
    step(15, 0, 0);
    for (int k = 0; k < 21; k++) wrap_cycle(0);
    step(15, 0, 0);
    chk("sat_drop_cnt", int'(drop_cnt), 15);
    chk("sat_wrap_cnt", int'(wrap_cnt), 21);

    // wrap_cnt rollover 255 -> 0.
    do_reset();
    step(15, 1, 0);
    for (int k = 0; k < 255; k++) wrap_cycle(1);
    step(15, 1, 0);
    chk("wc255_wrap_cnt", int'(wrap_cnt), 255);
    wrap_cycle(1);
    step(15, 1, 0);
    chk("roll_wrap_cnt", int'(wrap_cnt), 0);
    chk("roll_evt_valid", int'(evt_valid), 1);
    chk("roll_evt_data", int'(evt_data), 0);
    chk("roll_seq_err", int'(seq_err), 0);

    // Reset with an event pending, then an arbitrary first sample.
    do_reset();
    step(15, 0, 0);
    wrap_cycle(0);
    step(15, 0, 0);
    chk("pend_evt_valid", int'(evt_valid), 1);
    do_reset();
    step(3, 0, 0);
    step(3, 0, 0);
    chk("first_sample_seq_err", int'(seq_err), 0);
    step(2, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
`ifdef SEG7_EN
    chk("seg_zero", int'(seg_n), 'h40);
`endif
    chk("zero_count_q", int'(count_q), 0);

    // Random traffic: mostly legal counting, some holds, occasional jumps.
    do_reset();
    cur = 15;
    for (int n = 0; n < 1500; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 75) cur = (cur == 0) ? 15 : cur - 1;
      else if (r >= 95) cur = int'($urandom_range(0, 15));
      step(cur, int'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
